fisheye_frame_store: RTL and testbench

Double-buffered RGB565 frame store that answers read requests from the fisheye filter stage. A capture-side pixel stream writes one bank in raster order while the filter reads the other, completed bank through a one-cycle registered read port. Banks swap only when a full `IMG_WIDTH*IMG_HEIGHT` frame has been written, so the filter never sees a torn frame. The block sits between the camera capture path and the fisheye filter's read-address interface.

---
 rtl/fisheye_frame_store.sv | 106 ++++++++++
 tb/tb_fisheye_frame_store.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fisheye_frame_store.sv
// fisheye_frame_store: RGB565 frame store feeding the fisheye filter's read port.
// Ports: clk, reset (sync, active-high); frame_start, wr_valid, wr_data = raster-order capture stream;
// rd_addr -> rd_data (one-cycle registered read of the display bank); frame_ready, swap_pulse,
// overflow (sticky, beats dropped after completion), short_frame (sticky, partial frame aborted).
// Define FRAME_STORE_DOUBLE_BUFFER_EN for two ping-pong banks; otherwise one bank is written and read.
module fisheye_frame_store #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  wr_valid,
  input  logic [15:0]           wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [15:0]           rd_data,
  output logic                  frame_ready,
  output logic                  swap_pulse,
  output logic                  overflow,
  output logic                  short_frame
);
  localparam int N = IMG_WIDTH * IMG_HEIGHT;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, mem_waddr;
  logic [15:0]           rd_data_q, rd_data_d, rd_word;
  logic                  frame_ready_q, frame_ready_d;
  logic                  swap_pulse_q, swap_pulse_d;
  logic                  overflow_q, overflow_d;
  logic                  short_frame_q, short_frame_d;
  logic                  mem_we, last_beat;
`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
  logic                  wr_bank_q, wr_bank_d;
  logic [15:0]           mem0 [N];
  logic [15:0]           mem1 [N];
  // display bank is the one not being written
  assign rd_word = wr_bank_q ? mem0[rd_addr] : mem1[rd_addr];
`else
  logic [15:0]           mem [N];
  assign rd_word = mem[rd_addr];
`endif
  // frame_start always wins, so the final beat only counts without it
  assign last_beat = !frame_start && state_q == FILL && wr_valid && wr_addr_q == ADDR_WIDTH'(N - 1);
  assign mem_we    = !reset && wr_valid && (frame_start || state_q == FILL);
  assign mem_waddr = frame_start ? '0 : wr_addr_q;
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    frame_ready_d = frame_ready_q || last_beat;
    swap_pulse_d  = last_beat;
    overflow_d    = overflow_q || (!frame_start && state_q == DONE && wr_valid);
    short_frame_d = short_frame_q || (frame_start && state_q == FILL);
`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
    wr_bank_d     = wr_bank_q ^ last_beat;
`endif
    if (frame_start) begin
      state_d   = FILL;
      wr_addr_d = wr_valid ? ADDR_WIDTH'(1) : '0;
    end else if (state_q == FILL && wr_valid) begin
      state_d   = last_beat ? DONE : FILL;
      wr_addr_d = last_beat ? '0 : wr_addr_q + ADDR_WIDTH'(1);
    end
    // extra bit so rd_addr == N is caught even when N is a power of two
    rd_data_d = (!frame_ready_q || {1'b0, rd_addr} >= (ADDR_WIDTH + 1)'(N)) ? '0 : rd_word;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_data_q     <= '0;
      frame_ready_q <= 1'b0;
      swap_pulse_q  <= 1'b0;
      overflow_q    <= 1'b0;
      short_frame_q <= 1'b0;
`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
      wr_bank_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_data_q     <= rd_data_d;
      frame_ready_q <= frame_ready_d;
      swap_pulse_q  <= swap_pulse_d;
      overflow_q    <= overflow_d;
      short_frame_q <= short_frame_d;
`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
      wr_bank_q     <= wr_bank_d;
`endif
    end
  end
  // storage is never reset; a reset simply abandons whatever was partially written
  always_ff @(posedge clk) begin
`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
    if (mem_we && wr_bank_q) mem1[mem_waddr] <= wr_data;
    if (mem_we && !wr_bank_q) mem0[mem_waddr] <= wr_data;
`else
    if (mem_we) mem[mem_waddr] <= wr_data;
`endif
  end
  assign rd_data     = rd_data_q;
  assign frame_ready = frame_ready_q;
  assign swap_pulse  = swap_pulse_q;
  assign overflow    = overflow_q;
  assign short_frame = short_frame_q;
endmodule

// File: tb/tb_fisheye_frame_store.sv
// tb_fisheye_frame_store: scoreboard bench for fisheye_frame_store in either bank configuration.
module tb_fisheye_frame_store;
  localparam int W = 160, H = 120, N = W * H, AW = 15;
`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          reset, frame_start, wr_valid;
  logic [15:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          frame_ready, swap_pulse, overflow, short_frame;
  logic [15:0]   mem_m [2][N];
  logic [15:0]   exp_q [$];
  bit            wb, ready_m, ov_m, sf_m;
  int            checks = 0, errors = 0;

  fisheye_frame_store #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ready(frame_ready), .swap_pulse(swap_pulse),
    .overflow(overflow), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int p, input int a);
    logic [15:0] v;
    v = 16'(a);
    return p == 1 ? ~v : p == 2 ? v ^ 16'h5A5A : p == 3 ? v + 16'd3 : v;
  endfunction

  // one clock: drive inputs, queue the expected read, update the model, compare every output
  task automatic cycle(input bit fs, input bit wv, input logic [15:0] wd, input int ma, input bit last, input int ra);
    logic [15:0] e;
    frame_start = fs;
    wr_valid    = wv;
    wr_data     = wd;
    rd_addr     = AW'(ra);
    if (!ready_m || ra >= N) exp_q.push_back(16'h0000);
    else exp_q.push_back(mem_m[DB ? int'(!wb) : 0][ra]);
    @(posedge clk);
    #1;
    if (ma >= 0) mem_m[DB ? int'(wb) : 0][ma] = wd;
    if (last) begin
      wb      = !wb;
      ready_m = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== e) begin errors++; $display("FAIL rd_data addr=%0d got=%h exp=%h t=%0t", ra, rd_data, e, $time); end
    checks++;
    if (swap_pulse !== last) begin errors++; $display("FAIL swap_pulse got=%b exp=%b t=%0t", swap_pulse, last, $time); end
    checks++;
    if (frame_ready !== ready_m) begin errors++; $display("FAIL frame_ready got=%b exp=%b t=%0t", frame_ready, ready_m, $time); end
    checks++;
    if (overflow !== ov_m) begin errors++; $display("FAIL overflow got=%b exp=%b t=%0t", overflow, ov_m, $time); end
    checks++;
    if (short_frame !== sf_m) begin errors++; $display("FAIL short_frame got=%b exp=%b t=%0t", short_frame, sf_m, $time); end
  endtask

  task automatic fill(input int p, input int first, input int last_a);
    for (int a = first; a <= last_a; a++) cycle(1'b0, 1'b1, pat(p, a), a, a == N - 1, $urandom_range(0, N - 1));
  endtask

  task automatic test_reset;
    reset = 1'b1; frame_start = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; rd_addr = '0;
    wb = 1'b0; ready_m = 1'b0; ov_m = 1'b0; sf_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_data, frame_ready, swap_pulse, overflow, short_frame} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=00000", {rd_data, frame_ready, swap_pulse, overflow, short_frame});
    end
    reset = 1'b0;
    for (int a = 0; a < 6; a++) cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, a);
    for (int a = 0; a < 3; a++) cycle(1'b0, 1'b1, 16'hBEEF, -1, 1'b0, a);
  endtask

  task automatic test_first_frame;
    int          ra [3] = '{0, 159, 19199};
    logic [15:0] want [3] = '{16'h0000, 16'h009F, 16'h4AFF};
    cycle(1'b1, 1'b0, 16'h0, -1, 1'b0, 0);
    fill(0, 0, N - 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, ra[i]);
      checks++;
      if (rd_data !== want[i]) begin errors++; $display("FAIL first_frame_read addr=%0d got=%h exp=%h", ra[i], rd_data, want[i]); end
    end
  endtask

  task automatic test_second_frame;
    cycle(1'b1, 1'b0, 16'h0, -1, 1'b0, 1);
    fill(1, 0, N - 1);
    cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, 159);
    checks++;
    if (rd_data !== 16'hFF60) begin errors++; $display("FAIL second_frame_read got=%h exp=ff60", rd_data); end
  endtask

  task automatic test_short_frame;
    cycle(1'b1, 1'b0, 16'h0, -1, 1'b0, 2);
    fill(2, 0, 4999);
    sf_m = 1'b1;
    cycle(1'b1, 1'b1, 16'hF800, 0, 1'b0, 7);
    fill(3, 1, N - 1);
    cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, 0);
    checks++;
    if (rd_data !== 16'hF800) begin errors++; $display("FAIL start_pixel got=%h exp=f800", rd_data); end
  endtask

  task automatic test_out_of_range;
    cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, N);
    checks++;
    if (rd_data !== 16'h0000) begin errors++; $display("FAIL out_of_range got=%h exp=0000", rd_data); end
    cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, 32767);
  endtask

  task automatic test_overflow;
    ov_m = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'hDEAD, -1, 1'b0, $urandom_range(0, N - 1));
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, i * 997);
    cycle(1'b0, 1'b0, 16'h0, -1, 1'b0, 0);
    checks++;
    if (rd_data !== 16'hF800) begin errors++; $display("FAIL overflow_display got=%h exp=f800", rd_data); end
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_second_frame;
    test_short_frame;
    test_out_of_range;
    test_overflow;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
